// File: rtl/hall_sensor_emulator.sv
// rtl/hall_sensor_emulator.sv - BLDC Hall sensor emulator with timed sector stepping
//
// Purpose: steps an electrical sector 0..5 every PERIOD clock cycles while
// enabled and drives the matching registered Hall pattern on H1/H2/H3.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   EN         in   run enable for the step timer
//   DIR        in   0 = forward, 1 = reverse (sampled at step boundaries)
//   PERIOD     in   [15:0] clock cycles per step, 0 = stalled
//   LOAD       in   force SECTOR to SECT_IN (ignored when SECT_IN > 5)
//   SECT_IN    in   [2:0] sector value applied on LOAD
//   H1,H2,H3   out  registered Hall sensor signals
//   SECTOR     out  [2:0] current sector 0..5
//   STEP       out  one-cycle pulse on each timer-driven sector change
//   REV_CNT    out  [7:0] signed revolution count
//
// Configuration: define HALL_REV_COUNT_EN to build the revolution counter;
// otherwise REV_CNT is tied to zero.

module hall_sensor_emulator (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        DIR,
  input  logic [15:0] PERIOD,
  input  logic        LOAD,
  input  logic [2:0]  SECT_IN,
  output logic        H1,
  output logic        H2,
  output logic        H3,
  output logic [2:0]  SECTOR,
  output logic        STEP,
  output logic [7:0]  REV_CNT
);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sector_q, sector_d;
  logic [2:0]  hall_q, hall_d;
  logic        step_q, step_d;

  logic        period_nz;
  logic        fire;
  logic        load_ok;
  logic [2:0]  sector_next;

  // Sector to {H1,H2,H3}; unreachable codes fall back to the sector-0
  // pattern so 000/111 can never appear.
  function automatic logic [2:0] hall_map(input logic [2:0] s);
    case (s)
      3'd0:    hall_map = 3'b100;
      3'd1:    hall_map = 3'b101;
      3'd2:    hall_map = 3'b001;
      3'd3:    hall_map = 3'b011;
      3'd4:    hall_map = 3'b010;
      3'd5:    hall_map = 3'b110;
      default: hall_map = 3'b100;
    endcase
  endfunction

  assign period_nz = (PERIOD != 16'd0);
  // ">=" rather than "==" so a PERIOD shrink below the running count steps
  // on the next enabled cycle instead of waiting for a 16-bit wrap.
  assign fire      = EN && period_nz && (cnt_q >= (PERIOD - 16'd1));
  assign load_ok   = LOAD && (SECT_IN <= 3'd5);

  always_comb begin
    sector_next = sector_q;
    if (!DIR) begin
      sector_next = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
    end else begin
      sector_next = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sector_d = sector_q;
    hall_d   = hall_q;
    step_d   = 1'b0;
    if (load_ok) begin
      // LOAD wins over a coincident timer step and restarts the step timer.
      cnt_d    = 16'd0;
      sector_d = SECT_IN;
      hall_d   = hall_map(SECT_IN);
    end else if (EN) begin
      if (!period_nz) begin
        cnt_d = 16'd0;
      end else if (fire) begin
        cnt_d    = 16'd0;
        sector_d = sector_next;
        hall_d   = hall_map(sector_next);
        step_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q    <= 16'd0;
      sector_q <= 3'd0;
      hall_q   <= 3'b100;
      step_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sector_q <= sector_d;
      hall_q   <= hall_d;
      step_q   <= step_d;
    end
  end

`ifdef HALL_REV_COUNT_EN
  logic [7:0] rev_q, rev_d;

  always_comb begin
    rev_d = rev_q;
    if (!load_ok && fire) begin
      if (!DIR && (sector_q == 3'd5)) begin
        rev_d = rev_q + 8'd1;
      end else if (DIR && (sector_q == 3'd0)) begin
        rev_d = rev_q - 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rev_q <= 8'd0;
    end else begin
      rev_q <= rev_d;
    end
  end

  assign REV_CNT = rev_q;
`else
  assign REV_CNT = 8'd0;
`endif

  assign H1     = hall_q[2];
  assign H2     = hall_q[1];
  assign H3     = hall_q[0];
  assign SECTOR = sector_q;
  assign STEP   = step_q;

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// tb/tb_hall_sensor_emulator.sv - directed self-checking bench for hall_sensor_emulator

module tb_hall_sensor_emulator;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        DIR;
  logic [15:0] PERIOD;
  logic        LOAD;
  logic [2:0]  SECT_IN;
  logic        H1, H2, H3;
  logic [2:0]  SECTOR;
  logic        STEP;
  logic [7:0]  REV_CNT;

  int checks;
  int failures;

  logic [2:0] hall_tbl [0:5];
  logic [7:0] rev_fwd;
  logic [7:0] rev_back;
  logic [7:0] rev_exp;

  hall_sensor_emulator dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIR     (DIR),
    .PERIOD  (PERIOD),
    .LOAD    (LOAD),
    .SECT_IN (SECT_IN),
    .H1      (H1),
    .H2      (H2),
    .H3      (H3),
    .SECTOR  (SECTOR),
    .STEP    (STEP),
    .REV_CNT (REV_CNT)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] sec, input logic stp);
    check({tag, "_sector"}, {29'd0, SECTOR}, {29'd0, sec});
    check({tag, "_hall"}, {29'd0, H1, H2, H3}, {29'd0, hall_tbl[sec]});
    check({tag, "_step"}, {31'd0, STEP}, {31'd0, stp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hall_tbl[0] = 3'b100;
    hall_tbl[1] = 3'b101;
    hall_tbl[2] = 3'b001;
    hall_tbl[3] = 3'b011;
    hall_tbl[4] = 3'b010;
    hall_tbl[5] = 3'b110;
`ifdef HALL_REV_COUNT_EN
    rev_fwd  = 8'h01;
    rev_back = 8'hFF;
`else
    rev_fwd  = 8'h00;
    rev_back = 8'h00;
`endif

    RST = 1'b1; EN = 1'b0; DIR = 1'b0; PERIOD = 16'd25; LOAD = 1'b0; SECT_IN = 3'd0;
    repeat (3) @(negedge CLK);
    check_outs("reset", 3'd0, 1'b0);
    check("reset_rev", {24'd0, REV_CNT}, 32'd0);

    // Forward stepping, PERIOD=25: one step every 25 edges, full turn in 150.
    RST = 1'b0; EN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      repeat (24) @(negedge CLK);
      check_outs("fwd_pre", 3'((i - 1) % 6), 1'b0);
      @(negedge CLK);
      check_outs("fwd_step", 3'(i % 6), 1'b1);
    end
    check("fwd_rev", {24'd0, REV_CNT}, {24'd0, rev_fwd});

    // EN low mid-step freezes everything; resume finishes the remaining 15.
    repeat (10) @(negedge CLK);
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_outs("en_freeze", 3'd0, 1'b0);
    end
    EN = 1'b1;
    repeat (14) @(negedge CLK);
    check_outs("en_resume_pre", 3'd0, 1'b0);
    @(negedge CLK);
    check_outs("en_resume_step", 3'd1, 1'b1);

    // Reverse from a fresh reset: 5,4,3,2,1,0 every 4 cycles.
    RST = 1'b1;
    @(negedge CLK);
    check_outs("rst2", 3'd0, 1'b0);
    check("rst2_rev", {24'd0, REV_CNT}, 32'd0);
    RST = 1'b0; DIR = 1'b1; PERIOD = 16'd4;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge CLK);
      check("rev_pre_step", {31'd0, STEP}, 32'd0);
      @(negedge CLK);
      check_outs("rev_step", 3'(5 - i), 1'b1);
      if (i == 0) check("rev_cnt_first", {24'd0, REV_CNT}, {24'd0, rev_back});
    end
    check("rev_cnt_end", {24'd0, REV_CNT}, {24'd0, rev_back});

    // LOAD coinciding with a timer step wins and suppresses STEP.
    DIR = 1'b0;
    repeat (3) @(negedge CLK);
    LOAD = 1'b1; SECT_IN = 3'd3;
    @(negedge CLK);
    LOAD = 1'b0;
    check_outs("load_win", 3'd3, 1'b0);
    check("load_rev", {24'd0, REV_CNT}, {24'd0, rev_back});

    // SECT_IN=7 is ignored; the pending step happens normally.
    repeat (3) @(negedge CLK);
    LOAD = 1'b1; SECT_IN = 3'd7;
    @(negedge CLK);
    LOAD = 1'b0;
    check_outs("load_ign", 3'd4, 1'b1);

    // PERIOD=0 stalls: no steps for 100 cycles.
    PERIOD = 16'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check_outs("stall", 3'd4, 1'b0);
    end

    // PERIOD shrink 100 -> 10 at CNT=50 steps on the next edge, then every 10.
    PERIOD = 16'd100;
    repeat (50) @(negedge CLK);
    check_outs("shrink_pre", 3'd4, 1'b0);
    PERIOD = 16'd10;
    @(negedge CLK);
    check_outs("shrink_step", 3'd5, 1'b1);
    repeat (9) @(negedge CLK);
    check_outs("shrink_gap", 3'd5, 1'b0);
    @(negedge CLK);
    check_outs("shrink_next", 3'd0, 1'b1);
    rev_exp = rev_back + 8'(rev_fwd);
    check("shrink_rev", {24'd0, REV_CNT}, {24'd0, rev_exp});

    // Async reset between edges clears outputs before the next rising edge.
    repeat (4) @(negedge CLK);
    #5 RST = 1'b1;
    #1;
    check_outs("async_rst", 3'd0, 1'b0);
    check("async_rst_rev", {24'd0, REV_CNT}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (9) @(negedge CLK);
    check_outs("post_rst_pre", 3'd0, 1'b0);
    @(negedge CLK);
    check_outs("post_rst_step", 3'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hall_sensor_emulator.md
HALL_SENSOR_EMULATOR -- requirements
Module: hall_sensor_emulator

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port EN, input, 1 bit: run enable; when high, the step timer advances.
REQ-004 SHALL have port DIR, input, 1 bit: 0 = forward rotation, 1 = reverse rotation.
REQ-005 SHALL have port PERIOD, input, 16 bits: clock cycles per commutation step.
REQ-006 SHALL have port LOAD, input, 1 bit: forces the sector to SECT_IN.
REQ-007 SHALL have port SECT_IN, input, 3 bits: sector value applied on LOAD.
REQ-008 SHALL have ports H1, H2, H3, output, 1 bit each: registered Hall sensor signals for the BLDC commutation logic.
REQ-009 SHALL have port SECTOR, output, 3 bits: current sector, 0..5.
REQ-010 SHALL have port STEP, output, 1 bit: one-cycle pulse on each sector change caused by the timer.
REQ-011 SHALL have port REV_CNT, output, 8 bits: signed two's-complement revolution count.

Function
REQ-012 SHALL map sector to H1H2H3 as follows: 0=100, 1=101, 2=001, 3=011, 4=010, 5=110.
REQ-013 SHALL never output H1H2H3 = 000 or 111.
REQ-014 SHALL keep a 16-bit step counter CNT that increments each cycle while EN=1 and PERIOD!=0.
REQ-015 SHALL, when EN=1, PERIOD!=0 and CNT>=PERIOD-1, clear CNT, advance SECTOR, and assert STEP for exactly one cycle.
REQ-016 SHALL advance SECTOR in the forward direction (DIR=0) as 5 wraps to 0, otherwise +1.
REQ-017 SHALL advance SECTOR in the reverse direction (DIR=1) as 0 wraps to 5, otherwise -1.
REQ-018 SHALL sample DIR only at a step boundary; a DIR change mid-step SHALL NOT clear CNT.
REQ-019 SHALL update H1..H3 and SECTOR in the same cycle that STEP=1, with no extra pipeline latency between them.
REQ-020 SHALL hold CNT, SECTOR and the Hall outputs while EN=0; STEP=0 while EN=0.
REQ-021 SHALL treat PERIOD=0 as stalled: no steps, CNT held at 0.
REQ-022 SHALL apply a PERIOD decrease below the current CNT as a step on the next enabled cycle, because of the >= compare.
REQ-023 SHALL, on LOAD=1 with SECT_IN<=5, set SECTOR=SECT_IN and CNT=0 on the next edge, with STEP=0 and REV_CNT unchanged.
REQ-024 SHALL give LOAD priority over a simultaneous timer step.
REQ-025 SHALL ignore LOAD when SECT_IN is 6 or 7; the timer continues normally.
REQ-026 SHALL give a step period of exactly PERIOD cycles and an electrical revolution of exactly 6*PERIOD cycles.

Reset
REQ-027 SHALL, while RST=1, force immediately (asynchronously): CNT=0, SECTOR=0, H1H2H3=100, STEP=0, REV_CNT=0.
REQ-028 SHALL let an RST assertion mid-step discard the partial count.
REQ-029 SHALL begin counting from CNT=0 on the first rising edge after RST deasserts, if EN=1.

Configuration
REQ-030 SHALL include the revolution counter only when macro HALL_REV_COUNT_EN is defined.
REQ-031 SHALL, with HALL_REV_COUNT_EN defined: increment REV_CNT on a forward 5->0 step and decrement it on a reverse 0->5 step, with modulo-256 wrap.
REQ-032 SHALL, without HALL_REV_COUNT_EN: tie REV_CNT to 0 and synthesize no counter logic.
REQ-033 SHALL keep all other behaviour identical with and without the macro.

Verification
REQ-034 SHALL cover forward stepping: RST pulse, then EN=1, DIR=0, PERIOD=25 with a 40 ns clock -> H1H2H3 = 100,101,001,011,010,110 at 1000 ns intervals, STEP pulses 25 cycles apart, then 100 again at 6000 ns.
REQ-035 SHALL cover reverse rotation and revolution count: DIR=1, PERIOD=4 from sector 0 -> SECTOR sequence 5,4,3,2,1,0 and REV_CNT=0xFF after the first step (macro defined); REV_CNT stays 0 when the macro is undefined.
REQ-036 SHALL cover EN and PERIOD boundaries: EN=0 for 10 cycles mid-step -> no STEP and outputs frozen; resume completes the remaining count; PERIOD=0 -> no STEP for 100 cycles.
REQ-037 SHALL cover LOAD: LOAD=1, SECT_IN=3 coinciding with a timer step -> SECTOR=3, H1H2H3=011, STEP=0; SECT_IN=7 -> LOAD ignored.
REQ-038 SHALL cover PERIOD shrink: PERIOD changed from 100 to 10 when CNT=50 -> STEP on the next enabled cycle, then every 10 cycles.
REQ-039 SHALL cover asynchronous reset: RST asserted between clock edges mid-step -> all outputs at reset values before the next CLK edge.
